pipe_wb_stage: RTL

// Parametrised MEM->WB pipeline stage with valid/ready handshake, 2-entry skid buffer,

---
 rtl/pipe_wb_stage_if.sv | 42 ++++
 rtl/pipe_wb_stage.sv | 116 +++++++++++
 2 files changed

// File: rtl/pipe_wb_stage_if.sv
// MEM->WB handshake bundle: upstream result bus in, write-back bus out.
// PIPE_WB_FWD_EN adds the hazard-unit forwarding signals.
interface pipe_wb_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic          mwreg;
    logic          mm2reg;
    logic [DW-1:0] mmo;
    logic [DW-1:0] malu;
    logic [RW-1:0] mrn;
    logic          out_valid;
    logic          out_ready;
    logic          wwreg;
    logic          wm2reg;
    logic [DW-1:0] wmo;
    logic [DW-1:0] walu;
    logic [RW-1:0] wrn;
`ifdef PIPE_WB_FWD_EN
    logic          fwd_en;
    logic [RW-1:0] fwd_rn;
    logic [DW-1:0] fwd_data;
`endif

    modport slave (
        input  in_valid, mwreg, mm2reg, mmo, malu, mrn, out_ready,
`ifdef PIPE_WB_FWD_EN
        output fwd_en, fwd_rn, fwd_data,
`endif
        output in_ready, out_valid, wwreg, wm2reg, wmo, walu, wrn
    );

    modport master (
        output in_valid, mwreg, mm2reg, mmo, malu, mrn, out_ready,
`ifdef PIPE_WB_FWD_EN
        input  fwd_en, fwd_rn, fwd_data,
`endif
        input  in_ready, out_valid, wwreg, wm2reg, wmo, walu, wrn
    );
endinterface

// File: rtl/pipe_wb_stage.sv
// MEM->WB pipeline register with 2-entry skid buffer, flush and zero bubbles.
// Optional PIPE_WB_FWD_EN exposes forwarding outputs for the hazard unit.
module pipe_wb_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            flush,
    pipe_wb_stage_if.slave  bus
);
    typedef struct packed {
        logic          wreg;
        logic          m2reg;
        logic [DW-1:0] mo;
        logic [DW-1:0] alu;
        logic [RW-1:0] rn;
    } ent_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    ent_t   m_q, m_d;
    ent_t   s_q, s_d;
    ent_t   in_ent;
    logic   accept;
    logic   drain;
    logic   out_valid;

    assign in_ent = '{
        wreg:  bus.mwreg,
        m2reg: bus.mm2reg,
        mo:    bus.mmo,
        alu:   bus.malu,
        rn:    bus.mrn
    };

    // Ready depends only on registered state and clr, never on out_ready.
    assign bus.in_ready = (state_q != FULL) && !clr;
    assign out_valid    = (state_q != EMPTY);
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    m_d     = in_ent;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    m_d = in_ent;
                end else if (accept) begin
                    s_d     = in_ent;
                    state_d = FULL;
                end else if (drain) begin
                    m_d     = '0;
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    m_d     = s_q;
                    s_d     = '0;
                    state_d = ONE;
                end
            end
            default: begin
                m_d     = '0;
                s_d     = '0;
                state_d = EMPTY;
            end
        endcase
        if (flush) begin
            m_d     = '0;
            s_d     = '0;
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.wwreg     = m_q.wreg && out_valid;
    assign bus.wm2reg    = m_q.m2reg;
    assign bus.wmo       = m_q.mo;
    assign bus.walu      = m_q.alu;
    assign bus.wrn       = m_q.rn;

`ifdef PIPE_WB_FWD_EN
    logic fwd_en;
    assign fwd_en       = out_valid && m_q.wreg && (m_q.rn != '0);
    assign bus.fwd_en   = fwd_en;
    assign bus.fwd_rn   = fwd_en ? m_q.rn : '0;
    assign bus.fwd_data = !fwd_en ? '0 : (m_q.m2reg ? m_q.mo : m_q.alu);
`endif
endmodule
